// File: rtl/hd_program_loader_pkg.sv
// Shared state encoding and instruction-memory port constants for the HD program loader.
package hd_program_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR_REQ,
        ST_HDR_WAIT,
        ST_WORD_REQ,
        ST_WORD_WAIT,
        ST_WRITE,
        ST_CKS_REQ,
        ST_CKS_WAIT,
        ST_DONE
    } loader_state_t;

    localparam logic [2:0]  CTRL_SALVA_NONE    = 3'b000;
    localparam logic [2:0]  CTRL_SALVA_WRITE   = 3'b001;
    localparam logic [31:0] HDR_OFFSET         = 32'd0;
    localparam int          MEM_DEPTH_DEFAULT  = 201;
    localparam int          HD_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/hd_program_loader_if.sv
// HD word-read port: the loader issues address/read requests and receives valid-qualified data.
interface hd_program_loader_if;

    logic [31:0] hd_addr;
    logic        hd_rd_en;
    logic [31:0] hd_data;
    logic        hd_valid;

    modport master (output hd_addr, output hd_rd_en, input hd_data, input hd_valid);
    modport slave  (input hd_addr, input hd_rd_en, output hd_data, output hd_valid);

endinterface

// File: rtl/hd_program_loader.sv
// Copies a length-prefixed program image from the HD port into instruction memory.
// Optional trailing XOR checksum word is enabled with `define LOADER_CHECKSUM_EN.
module hd_program_loader
    import hd_program_loader_pkg::*;
#(
    parameter int MEM_DEPTH  = MEM_DEPTH_DEFAULT,
    parameter int HD_TIMEOUT = HD_TIMEOUT_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          hd_base,
    hd_program_loader_if.master  hd,
    output logic [31:0]          entradaDeInstrucao,
    output logic [31:0]          posicaoParaSalvarInstrucao,
    output logic [2:0]           controleSalvaInstrucao,
    output logic                 encerrarBios,
    output logic                 busy,
    output logic                 erro
);

    loader_state_t state_q, state_d;
    logic [31:0]   base_q, base_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   idx_q, idx_d;
    logic [31:0]   word_q, word_d;
    logic [31:0]   tcnt_q, tcnt_d;
    logic          erro_q, erro_d;
    logic          in_wait;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]   cks_q, cks_d;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            tcnt_q  <= '0;
            erro_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            cks_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            tcnt_q  <= tcnt_d;
            erro_q  <= erro_d;
`ifdef LOADER_CHECKSUM_EN
            cks_q   <= cks_d;
`endif
        end
    end

    assign in_wait = (state_q == ST_HDR_WAIT) || (state_q == ST_WORD_WAIT) ||
                     (state_q == ST_CKS_WAIT);

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        idx_d   = idx_q;
        word_d  = word_q;
        tcnt_d  = tcnt_q;
        erro_d  = erro_q;
`ifdef LOADER_CHECKSUM_EN
        cks_d   = cks_q;
`endif
        hd.hd_rd_en                = 1'b0;
        hd.hd_addr                 = '0;
        entradaDeInstrucao         = '0;
        posicaoParaSalvarInstrucao = '0;
        controleSalvaInstrucao     = CTRL_SALVA_NONE;
        encerrarBios               = 1'b0;

        // Every wait state shares one timeout: give up after HD_TIMEOUT silent cycles.
        if (in_wait && !hd.hd_valid) begin
            if (tcnt_q == 32'(HD_TIMEOUT - 1)) begin
                erro_d  = 1'b1;
                state_d = ST_IDLE;
            end else begin
                tcnt_d = tcnt_q + 32'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = hd_base;
                    erro_d  = 1'b0;
                    idx_d   = '0;
                    state_d = ST_HDR_REQ;
`ifdef LOADER_CHECKSUM_EN
                    cks_d   = '0;
`endif
                end
            end
            ST_HDR_REQ: begin
                hd.hd_rd_en = 1'b1;
                hd.hd_addr  = base_q + HDR_OFFSET;
                tcnt_d      = '0;
                state_d     = ST_HDR_WAIT;
            end
            ST_HDR_WAIT: begin
                hd.hd_rd_en = 1'b1;
                hd.hd_addr  = base_q + HDR_OFFSET;
                if (hd.hd_valid) begin
                    if (hd.hd_data == 32'd0) begin
                        state_d = ST_DONE;
                    end else if (hd.hd_data > 32'(MEM_DEPTH)) begin
                        count_d = 32'(MEM_DEPTH);
                        erro_d  = 1'b1;
                        state_d = ST_WORD_REQ;
                    end else begin
                        count_d = hd.hd_data;
                        state_d = ST_WORD_REQ;
                    end
                end
            end
            ST_WORD_REQ: begin
                hd.hd_rd_en = 1'b1;
                hd.hd_addr  = base_q + 32'd1 + idx_q;
                tcnt_d      = '0;
                state_d     = ST_WORD_WAIT;
            end
            ST_WORD_WAIT: begin
                hd.hd_rd_en = 1'b1;
                hd.hd_addr  = base_q + 32'd1 + idx_q;
                if (hd.hd_valid) begin
                    word_d  = hd.hd_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                controleSalvaInstrucao     = CTRL_SALVA_WRITE;
                posicaoParaSalvarInstrucao = idx_q;
                entradaDeInstrucao         = word_q;
                idx_d                      = idx_q + 32'd1;
`ifdef LOADER_CHECKSUM_EN
                cks_d                      = cks_q ^ word_q;
                state_d = (idx_q + 32'd1 == count_q) ? ST_CKS_REQ : ST_WORD_REQ;
`else
                state_d = (idx_q + 32'd1 == count_q) ? ST_DONE : ST_WORD_REQ;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CKS_REQ: begin
                hd.hd_rd_en = 1'b1;
                hd.hd_addr  = base_q + 32'd1 + idx_q;
                tcnt_d      = '0;
                state_d     = ST_CKS_WAIT;
            end
            ST_CKS_WAIT: begin
                hd.hd_rd_en = 1'b1;
                hd.hd_addr  = base_q + 32'd1 + idx_q;
                if (hd.hd_valid) begin
                    if (hd.hd_data == cks_q) begin
                        state_d = ST_DONE;
                    end else begin
                        erro_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
`endif
            ST_DONE: begin
                encerrarBios = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);
    assign erro = erro_q;

endmodule

// File: tb/tb_hd_program_loader.sv
// Self-checking bench for hd_program_loader: HD image responder plus a write-sequence model.
module tb_hd_program_loader;

    localparam int MEM_DEPTH = 201;

    typedef struct {
        logic [31:0] pos;
        logic [31:0] data;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] hd_base = '0;
    logic [31:0] entradaDeInstrucao;
    logic [31:0] posicaoParaSalvarInstrucao;
    logic [2:0]  controleSalvaInstrucao;
    logic        encerrarBios;
    logic        busy;
    logic        erro;

    hd_program_loader_if hd ();

    hd_program_loader dut (
        .clock                      (clock),
        .reset                      (reset),
        .start                      (start),
        .hd_base                    (hd_base),
        .hd                         (hd),
        .entradaDeInstrucao         (entradaDeInstrucao),
        .posicaoParaSalvarInstrucao (posicaoParaSalvarInstrucao),
        .controleSalvaInstrucao     (controleSalvaInstrucao),
        .encerrarBios               (encerrarBios),
        .busy                       (busy),
        .erro                       (erro)
    );

    always #5 clock = ~clock;

    wr_t         exp_q[$];
    logic [31:0] wr_pos[$];
    logic [31:0] wr_dat[$];
    logic [31:0] img [0:511];
    logic [31:0] img_base = '0;
    int          tests = 0;
    int          fails = 0;
    int          lat = 2;
    int          budget = -1;
    int          wcnt = 0;
    int          done_cycles = 0;
    int          busy_cycles = 0;
    int          word1_rd_cycles = 0;
    logic        exp_err = 1'b0;
    logic        exp_done = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] imgRead(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - img_base;
        if (off < 32'd512) return img[off[8:0]];
        return 32'hDEAD_BEEF;
    endfunction

    // Disk model: answers each read request `lat` cycles later, until the response budget runs out.
    initial begin
        hd.hd_valid = 1'b0;
        hd.hd_data  = '0;
        forever begin
            @(negedge clock);
            if (hd.hd_rd_en && budget != 0) begin
                if (wcnt >= lat) begin
                    hd.hd_valid = 1'b1;
                    hd.hd_data  = imgRead(hd.hd_addr);
                    wcnt        = 0;
                    if (budget > 0) budget--;
                end else begin
                    hd.hd_valid = 1'b0;
                    wcnt++;
                end
            end else begin
                hd.hd_valid = 1'b0;
                wcnt        = 0;
            end
        end
    end

    always @(negedge clock) begin : monitor
        wr_t e;
        if (controleSalvaInstrucao != 3'b000) begin
            checkOutput("ctrl_code", 32'(controleSalvaInstrucao), 32'd1);
            wr_pos.push_back(posicaoParaSalvarInstrucao);
            wr_dat.push_back(entradaDeInstrucao);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_write: got pos %0d, expected no write",
                         posicaoParaSalvarInstrucao);
            end else begin
                e = exp_q.pop_front();
                checkOutput("wr_pos", posicaoParaSalvarInstrucao, e.pos);
                checkOutput("wr_data", entradaDeInstrucao, e.data);
            end
        end
        if (encerrarBios) done_cycles++;
        if (busy) busy_cycles++;
        if (hd.hd_rd_en && hd.hd_addr == img_base + 32'd1) word1_rd_cycles++;
    end

    task automatic buildImage(input logic [31:0] base, input int n);
        img_base = base;
        for (int k = 0; k < 512; k++) img[k] = '0;
        img[0] = 32'(n);
        for (int k = 0; k < n && k < 509; k++)
            img[1 + k] = 32'h1000_0000 + base * 32'h100 + 32'(k) * 32'h0001_0003;
    endtask

    task automatic fixChecksum(input int n);
        int          nw;
        logic [31:0] x;
        nw = (n > MEM_DEPTH) ? MEM_DEPTH : n;
        x  = '0;
        for (int k = 0; k < nw; k++) x ^= img[1 + k];
        img[1 + nw] = x;
    endtask

    // Expected outcome from the image rules: first min(N, depth) words land at 0.., clamp flags erro.
    task automatic buildModel(input int n);
        int          nw;
        logic [31:0] x;
        wr_t         w;
        exp_q.delete();
        nw = (n > MEM_DEPTH) ? MEM_DEPTH : n;
        x  = '0;
        for (int k = 0; k < nw; k++) begin
            w.pos  = 32'(k);
            w.data = img[1 + k];
            exp_q.push_back(w);
            x ^= img[1 + k];
        end
        exp_err  = (n > MEM_DEPTH);
        exp_done = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        if (n != 0 && x != img[1 + nw]) begin
            exp_err  = 1'b1;
            exp_done = 1'b0;
        end
`endif
    endtask

    task automatic clearStats();
        done_cycles     = 0;
        busy_cycles     = 0;
        word1_rd_cycles = 0;
        wr_pos.delete();
        wr_dat.delete();
    endtask

    task automatic applyStimulus(input logic [31:0] base, input int latency, input int resp_budget,
                                 input bit inject);
        int cyc;
        lat    = latency;
        budget = resp_budget;
        clearStats();
        @(negedge clock);
        hd_base = base;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        hd_base = '0;
        cyc     = 0;
        while (busy && cyc < 5000) begin
            if (inject && cyc == 6) begin
                start   = 1'b1;
                hd_base = base + 32'd37;
            end else begin
                start   = 1'b0;
                hd_base = '0;
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 5000) checkOutput("load_bound", 32'(busy), 32'd0);
    endtask

    task automatic checkScenario(input string name);
        checkOutput({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        checkOutput({name, "_done_pulse"}, 32'(done_cycles), 32'(exp_done));
        checkOutput({name, "_erro"}, 32'(erro), 32'(exp_err));
        checkOutput({name, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_hd_addr"}, hd.hd_addr, 32'd0);
        checkOutput({name, "_hd_rd_en"}, 32'(hd.hd_rd_en), 32'd0);
        checkOutput({name, "_entrada"}, entradaDeInstrucao, 32'd0);
        checkOutput({name, "_posicao"}, posicaoParaSalvarInstrucao, 32'd0);
        checkOutput({name, "_ctrl"}, 32'(controleSalvaInstrucao), 32'd0);
        checkOutput({name, "_encerrar"}, 32'(encerrarBios), 32'd0);
        checkOutput({name, "_busy"}, 32'(busy), 32'd0);
        checkOutput({name, "_erro"}, 32'(erro), 32'd0);
    endtask

    initial begin
        int cyc;

        reset = 1'b0;
        repeat (3) @(negedge clock);
        checkAllZero("reset");
        reset = 1'b1;
        @(negedge clock);

        // Three literal words, start pulsed mid-load with a different base.
        buildImage(32'd100, 3);
        img[1] = 32'hAAAA_0001;
        img[2] = 32'hBBBB_0002;
        img[3] = 32'hCCCC_0003;
        fixChecksum(3);
        buildModel(3);
        applyStimulus(32'd100, 2, -1, 1'b1);
        checkScenario("t1");
        checkOutput("t1_write_count", 32'(wr_pos.size()), 32'd3);
        if (wr_dat.size() == 3) begin
            checkOutput("t1_word0", wr_dat[0], 32'hAAAA_0001);
            checkOutput("t1_word2", wr_dat[2], 32'hCCCC_0003);
            checkOutput("t1_pos2", wr_pos[2], 32'd2);
        end
`ifdef LOADER_CHECKSUM_EN
        checkOutput("t1_busy_cycles", 32'(busy_cycles), 32'd19);
`else
        checkOutput("t1_busy_cycles", 32'(busy_cycles), 32'd16);
`endif

        // Empty image: header then straight to the completion pulse.
        buildImage(32'd40, 0);
        buildModel(0);
        applyStimulus(32'd40, 2, -1, 1'b0);
        checkScenario("t2");
        checkOutput("t2_busy_cycles", 32'(busy_cycles), 32'd4);

        // Oversized image clamps to memory depth; start during busy must not clear erro.
        buildImage(32'd7, 300);
        fixChecksum(300);
        buildModel(300);
        applyStimulus(32'd7, 1, -1, 1'b1);
        checkScenario("t3");
        checkOutput("t3_write_count", 32'(wr_pos.size()), 32'd201);
        if (wr_pos.size() == 201) checkOutput("t3_last_pos", wr_pos[200], 32'd200);

        // Disk goes silent after the header: timeout abort, no completion pulse.
        buildImage(32'd50, 3);
        fixChecksum(3);
        exp_q.delete();
        exp_err  = 1'b1;
        exp_done = 1'b0;
        applyStimulus(32'd50, 2, 1, 1'b0);
        checkScenario("t4");
        checkOutput("t4_word1_rd_cycles", 32'(word1_rd_cycles), 32'd256);

        // Zero latency puts hd_valid in the request cycles too; erro from before must clear.
        buildImage(32'd300, 5);
        fixChecksum(5);
        buildModel(5);
        applyStimulus(32'd300, 0, -1, 1'b0);
        checkScenario("t5");

        // Reset while waiting on the second word: only the first write survives.
        buildImage(32'd200, 4);
        fixChecksum(4);
        buildModel(4);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        exp_err  = 1'b0;
        exp_done = 1'b0;
        lat      = 6;
        budget   = -1;
        clearStats();
        @(negedge clock);
        hd_base = 32'd200;
        start   = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        cyc     = 0;
        while (!(hd.hd_rd_en && hd.hd_addr == 32'd202) && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        checkOutput("t6_reached_word2", 32'(cyc < 200), 32'd1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkAllZero("t6_after_reset");
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checkScenario("t6");
        checkOutput("t6_write_count", 32'(wr_pos.size()), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        buildImage(32'd60, 2);
        img[1] = 32'h0000_000F;
        img[2] = 32'h0000_00F0;
        img[3] = 32'h0000_00FF;
        buildModel(2);
        applyStimulus(32'd60, 2, -1, 1'b0);
        checkScenario("t7_good");
        checkOutput("t7_good_erro", 32'(erro), 32'd0);

        img[3] = 32'h0000_0000;
        buildModel(2);
        applyStimulus(32'd60, 2, -1, 1'b0);
        checkScenario("t7_bad");
        checkOutput("t7_bad_done", 32'(done_cycles), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
